// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              done_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              done_b;
    logic [DATA_W-1:0] rdata_b;

    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  mem_rdata,
        output gnt_a, done_a, rdata_a,
        output gnt_b, done_b, rdata_b,
        output busy, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output mem_rdata,
        input  gnt_a, done_a, rdata_a,
        input  gnt_b, done_b, rdata_b,
        input  busy, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port RAM.
// One transaction at a time: IDLE (arbitrate) -> ACCESS (strobe held) -> DONE (done pulse).
module mem_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          clear_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // A zero wait count would leave no cycle for the strobe, so it is clamped to one.
    localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W = (W_EFF > 1) ? $clog2(W_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W_EFF - 1);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;        // 0: A has priority, 1: B
    logic              owner_q, owner_d;    // 0: A owns the access, 1: B
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic              done_a_q, done_a_d, done_b_q, done_b_d;
    logic              busy_q, busy_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              pick_b;
    logic              we_sel;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        busy_d      = busy_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        pick_b      = 1'b0;
        we_sel      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (bus.req_a || bus.req_b) begin
                    pick_b      = bus.req_b && (!bus.req_a || ptr_q);
                    we_sel      = pick_b ? bus.we_b : bus.we_a;
                    owner_d     = pick_b;
                    ptr_d       = !pick_b;
                    we_d        = we_sel;
                    mem_addr_d  = pick_b ? bus.addr_b  : bus.addr_a;
                    mem_wdata_d = pick_b ? bus.wdata_b : bus.wdata_a;
                    gnt_a_d     = !pick_b;
                    gnt_b_d     = pick_b;
                    mem_read_d  = !we_sel;
                    mem_write_d = we_sel;
                    cnt_d       = CNT_LOAD;
                    busy_d      = 1'b1;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) rdata_b_d = bus.mem_rdata;
                        else         rdata_a_d = bus.mem_rdata;
                    end
                    done_a_d    = !owner_q;
                    done_b_d    = owner_q;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Reset drops any in-flight access: strobes and pulses clear asynchronously.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.rdata_a   = rdata_a_q;
    assign bus.rdata_b   = rdata_b_q;
    assign bus.busy      = busy_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with a 1-cycle window, one with a 3-cycle window,
// each on its own RAM model; completions are checked against a queue of expected results.
module tb_mem_arbiter;

    logic clk;
    logic clear_n;

    mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) if1 ();
    mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) if3 ();

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (if1)
    );

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;   // 0: A, 1: B
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1, e3;

    // Preloaded RAM contents (stands in for the memory image).
    function automatic logic [31:0] init_val(input int a);
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    logic [31:0] ram1 [512];
    logic [31:0] ram3 [512];

    // Asynchronous-read, synchronous-write RAM models.
    initial begin
        for (int i = 0; i < 512; i++) ram1[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (if1.mem_write) ram1[if1.mem_addr] <= if1.mem_wdata;
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) ram3[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (if3.mem_write) ram3[if3.mem_addr] <= if3.mem_wdata;
        end
    end

    assign if1.mem_rdata = ram1[if1.mem_addr];
    assign if3.mem_rdata = ram3[if3.mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exclusivity of strobes and pulses, every cycle out of reset.
    always @(negedge clk) begin
        if (clear_n) begin
            check("excl_strobe_w1", 32'(if1.mem_read & if1.mem_write), 32'd0);
            check("excl_gnt_w1",    32'(if1.gnt_a & if1.gnt_b),        32'd0);
            check("excl_strobe_w3", 32'(if3.mem_read & if3.mem_write), 32'd0);
            check("excl_done_w3",   32'(if3.done_a & if3.done_b),      32'd0);
        end
    end

    // Scoreboards: every done pulse pops one expected completion.
    always @(negedge clk) begin
        if (clear_n && (if1.done_a || if1.done_b)) begin
            if (sb1.size() == 0) begin
                check("sb_w1_spurious_done", {30'd0, if1.done_b, if1.done_a}, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                check("sb_w1_port", 32'(if1.done_b), 32'(e1.port));
                if (e1.rd) check("sb_w1_rdata", e1.port ? if1.rdata_b : if1.rdata_a, e1.data);
            end
        end
    end

    always @(negedge clk) begin
        if (clear_n && (if3.done_a || if3.done_b)) begin
            if (sb3.size() == 0) begin
                check("sb_w3_spurious_done", {30'd0, if3.done_b, if3.done_a}, 32'd0);
            end else begin
                e3 = sb3.pop_front();
                check("sb_w3_port", 32'(if3.done_b), 32'(e3.port));
                if (e3.rd) check("sb_w3_rdata", e3.port ? if3.rdata_b : if3.rdata_a, e3.data);
            end
        end
    end

    function automatic exp_t mk(input bit port, input bit rd, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

    // Counts negedges from the call until a grant appears; port=-1 on timeout.
    task automatic wait_gnt(input bit d3, output int port, output int n);
        port = -1;
        n    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d3 ? if3.gnt_a : if1.gnt_a) begin port = 0; n = k; break; end
            if (d3 ? if3.gnt_b : if1.gnt_b) begin port = 1; n = k; break; end
        end
        if (port < 0) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input bit d3);
        for (int k = 0; k < 20; k++) begin
            if ((d3 ? sb3.size() : sb1.size()) == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(d3 ? sb3.size() : sb1.size()), 32'd0);
    endtask

    task automatic to_idle(input bit d3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!(d3 ? if3.busy : if1.busy)) break;
        end
        check("to_idle", 32'(d3 ? if3.busy : if1.busy), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_flags_w1"}, {25'd0, if1.gnt_a, if1.gnt_b, if1.done_a, if1.done_b,
                                   if1.busy, if1.mem_read, if1.mem_write}, 32'd0);
        check({tag, "_addr_w1"},  32'(if1.mem_addr), 32'd0);
        check({tag, "_wdata_w1"}, if1.mem_wdata, 32'd0);
        check({tag, "_rdata_w1"}, if1.rdata_a | if1.rdata_b, 32'd0);
        check({tag, "_flags_w3"}, {25'd0, if3.gnt_a, if3.gnt_b, if3.done_a, if3.done_b,
                                   if3.busy, if3.mem_read, if3.mem_write}, 32'd0);
        check({tag, "_rdata_w3"}, if3.rdata_a | if3.rdata_b, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int port, n;
    int gnt_at, rd_cnt, addr_bad, done_at, busy_cnt;

    initial begin
        clear_n = 1'b0;
        {if1.req_a, if1.we_a, if1.req_b, if1.we_b} = '0;
        {if3.req_a, if3.we_a, if3.req_b, if3.we_b} = '0;
        if1.addr_a = '0; if1.addr_b = '0; if1.wdata_a = '0; if1.wdata_b = '0;
        if3.addr_a = '0; if3.addr_b = '0; if3.wdata_a = '0; if3.wdata_b = '0;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        check_cleared("reset");

        // Both ports requesting reads from reset: A,B,A,B, three cycles apart.
        if1.req_a = 1'b1; if1.addr_a = 9'h000;
        if1.req_b = 1'b1; if1.addr_b = 9'h1FF;
        sb1.push_back(mk(1'b0, 1'b1, init_val(9'h000)));
        sb1.push_back(mk(1'b1, 1'b1, init_val(9'h1FF)));
        sb1.push_back(mk(1'b0, 1'b1, init_val(9'h000)));
        sb1.push_back(mk(1'b1, 1'b1, init_val(9'h1FF)));
        clear_n = 1'b1;
        wait_gnt(1'b0, port, n);
        check("rr_first_port", 32'(port), 32'd0);
        check("rr_first_lat",  32'(n),    32'd1);
        for (int g = 1; g < 4; g++) begin
            wait_gnt(1'b0, port, n);
            check("rr_port",    32'(port), 32'(g % 2));
            check("rr_spacing", 32'(n),    32'd3);
        end
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        drain(1'b0);

        // Port A write then read-back of 0x1A5.
        to_idle(1'b0);
        if1.req_a = 1'b1; if1.we_a = 1'b1; if1.addr_a = 9'h1A5; if1.wdata_a = 32'hDEADBEEF;
        sb1.push_back(mk(1'b0, 1'b0, 32'd0));
        wait_gnt(1'b0, port, n);
        check("wr_port", 32'(port), 32'd0);
        check("wr_lat",  32'(n),    32'd1);
        check("wr_strobes", {30'd0, if1.mem_read, if1.mem_write}, 32'd1);
        check("wr_addr",  32'(if1.mem_addr), 32'h1A5);
        check("wr_wdata", if1.mem_wdata, 32'hDEADBEEF);
        if1.req_a = 1'b0;
        @(negedge clk);
        check("wr_done", 32'(if1.done_a), 32'd1);
        to_idle(1'b0);
        if1.req_a = 1'b1; if1.we_a = 1'b0;
        sb1.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
        wait_gnt(1'b0, port, n);
        check("rd_lat", 32'(n), 32'd1);
        check("rd_strobes", {30'd0, if1.mem_read, if1.mem_write}, 32'd2);
        if1.req_a = 1'b0;
        @(negedge clk);
        check("rd_done",    32'(if1.done_a), 32'd1);
        check("rd_rdata_a", if1.rdata_a, 32'hDEADBEEF);
        check("rd_rdata_b_kept", if1.rdata_b, init_val(9'h1FF));
        drain(1'b0);

        // B pulsed for one cycle during A's access; A's address changes after its grant.
        to_idle(1'b0);
        if1.req_a = 1'b1; if1.we_a = 1'b0; if1.addr_a = 9'h020;
        sb1.push_back(mk(1'b0, 1'b1, init_val(9'h020)));
        wait_gnt(1'b0, port, n);
        check("pulse_a_port", 32'(port), 32'd0);
        if1.req_a = 1'b0; if1.addr_a = 9'h0AA;
        if1.req_b = 1'b1; if1.we_b = 1'b1; if1.addr_b = 9'h030; if1.wdata_b = 32'h0BAD_F00D;
        @(negedge clk);
        if1.req_b = 1'b0;
        check("pulse_addr_held", 32'(if1.mem_addr), 32'h020);
        check("pulse_done_a", 32'(if1.done_a), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pulse_no_b", {30'd0, if1.gnt_b, if1.mem_write}, 32'd0);
        end
        check("pulse_ram_b", ram1[9'h030], init_val(9'h030));
        drain(1'b0);

        // Reset in the middle of an A write: strobe falls at once, no done, pointer back to A.
        to_idle(1'b0);
        if1.req_a = 1'b1; if1.we_a = 1'b1; if1.addr_a = 9'h050; if1.wdata_a = 32'h1234_5678;
        wait_gnt(1'b0, port, n);
        check("rst_wr_strobe", 32'(if1.mem_write), 32'd1);
        #2 clear_n = 1'b0;
        #1 check_cleared("midrst");
        if1.we_a = 1'b0; if1.addr_a = 9'h003;
        if1.req_b = 1'b1; if1.we_b = 1'b0; if1.addr_b = 9'h004;
        sb1.push_back(mk(1'b0, 1'b1, init_val(9'h003)));
        sb1.push_back(mk(1'b1, 1'b1, init_val(9'h004)));
        repeat (2) @(negedge clk);
        check("rst_write_dropped", ram1[9'h050], init_val(9'h050));
        clear_n = 1'b1;
        wait_gnt(1'b0, port, n);
        check("rst_ptr_port", 32'(port), 32'd0);
        check("rst_ptr_lat",  32'(n),    32'd1);
        wait_gnt(1'b0, port, n);
        check("rst_second_port", 32'(port), 32'd1);
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        drain(1'b0);

        // Three-cycle window: B read of 0x010.
        if3.req_b = 1'b1; if3.we_b = 1'b0; if3.addr_b = 9'h010;
        sb3.push_back(mk(1'b1, 1'b1, init_val(9'h010)));
        gnt_at = 0; rd_cnt = 0; addr_bad = 0; done_at = 0; busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (if3.gnt_b) begin gnt_at = k; if3.req_b = 1'b0; end
            if (if3.mem_read) begin
                rd_cnt++;
                if (if3.mem_addr !== 9'h010) addr_bad++;
            end
            if (if3.busy)   busy_cnt++;
            if (if3.done_b) done_at = k;
        end
        check("w3_gnt_lat",    32'(gnt_at),   32'd1);
        check("w3_read_len",   32'(rd_cnt),   32'd3);
        check("w3_addr_bad",   32'(addr_bad), 32'd0);
        check("w3_done_lat",   32'(done_at),  32'd4);
        // busy spans the three ACCESS cycles plus the DONE cycle.
        check("w3_busy_len",   32'(busy_cnt), 32'd4);
        check("w3_rdata_b",    if3.rdata_b,   init_val(9'h010));
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
